trig_rr_scheduler: RTL

//  Round-robin scheduler sharing the single a_clk-domain trigger input of the twoclksync crossing between N requesters.

---
 rtl/trig_rr_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/trig_rr_scheduler.sv
// rtl/trig_rr_scheduler.sv - round-robin trigger scheduler with holdoff, feeding twoclksync a_trig
// Define TRIG_ACK_WAIT_EN to add the far-side ack wait with timeout after each holdoff.
module trig_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int HOLDOFF = 6,
  parameter int TIMEOUT = 32,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             glb_arst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             trig_out,
  output logic [IDW-1:0]   trig_id,
  output logic             busy,
  input  logic             trig_ack,
  output logic             timeout_err
);
  localparam int CW = $clog2(HOLDOFF + 1);

`ifdef TRIG_ACK_WAIT_EN
  typedef enum logic [1:0] {IDLE, FIRE, HOLD, WAIT_ACK} state_t;
`else
  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;
`endif

  state_t         state, state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] scan_idx;
  logic           scan_hit;
  logic [CW-1:0]  hold_cnt;
  logic           hold_done;

  // HOLD lasts HOLDOFF-1 cycles so trigger spacing is HOLDOFF+1 including the IDLE decision.
  assign hold_done = (hold_cnt == CW'(1));

`ifdef TRIG_ACK_WAIT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic          ack_latch;
  logic          ack_seen;
  logic          wait_done;
  logic [TW-1:0] wait_cnt;

  assign ack_seen    = ack_latch | trig_ack;
  assign wait_done   = (wait_cnt == TW'(TIMEOUT - 1));
  assign timeout_err = (state == WAIT_ACK) && wait_done && !ack_seen && !glb_arst;

  always_ff @(posedge clk) begin
    if (glb_arst) begin
      ack_latch <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      // An ack seen early (FIRE/HOLD) is remembered; a new trigger starts a fresh wait.
      if (state == IDLE && |req) ack_latch <= 1'b0;
      else if (trig_ack)         ack_latch <= 1'b1;
      if (state == WAIT_ACK) wait_cnt <= wait_cnt + TW'(1);
      else                   wait_cnt <= '0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_ack;
  assign unused_ack  = trig_ack;
  assign timeout_err = 1'b0;
`endif

  // Rotating search starting just after the last winner.
  always_comb begin
    winner   = ptr;
    scan_idx = '0;
    scan_hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = IDW'((int'(ptr) + i) % N_REQ);
      if (!scan_hit && req[scan_idx]) begin
        winner   = scan_idx;
        scan_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (|req) state_next = FIRE;
      FIRE: state_next = HOLD;
`ifdef TRIG_ACK_WAIT_EN
      HOLD: if (hold_done) state_next = WAIT_ACK;
      WAIT_ACK: if (ack_seen || wait_done) state_next = IDLE;
`else
      HOLD: if (hold_done) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (glb_arst) begin
      state    <= IDLE;
      ptr      <= IDW'(N_REQ - 1);
      trig_id  <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && |req) begin
        ptr     <= winner;
        trig_id <= winner;
      end
      if (state == FIRE)      hold_cnt <= CW'(HOLDOFF - 1);
      else if (state == HOLD) hold_cnt <= hold_cnt - CW'(1);
    end
  end

  // Outputs are masked while reset is asserted so an aborted FIRE never leaks a pulse.
  assign trig_out = (state == FIRE) && !glb_arst;
  assign grant    = trig_out ? (N_REQ'(1) << trig_id) : '0;
  assign busy     = (state != IDLE);
endmodule
